// File: rtl/tcp_tx_pkt_gen.sv
// ============================================================================
// Module   : tcp_tx_pkt_gen
// Brief    : Per-command TCP transmit segment generator: reads flow state and
//            buffer pointers, sizes one segment, writes back and enqueues it.
//            Optional macro TCP_TX_WND_CLAMP_EN also clamps to the peer window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tcp_tx_pkt_gen_pkg;
    localparam int TX_PAYLOAD_PTR_W = 12;
    localparam int FLOWID_W         = 8;

    localparam logic [7:0] c_flag_ack = 8'h10;
    localparam logic [7:0] c_flag_psh = 8'h08;

    typedef struct packed {
        logic [31:0] seq_num;
        logic [31:0] ack_num;
        logic [15:0] peer_wnd;
    } smol_tx_state_struct;

    typedef struct packed {
        logic [31:0] seq_num;
        logic [31:0] ack_num;
        logic [7:0]  flags;
    } tcp_pkt_hdr;
endpackage

module tcp_tx_pkt_gen
    import tcp_tx_pkt_gen_pkg::*;
#(
    parameter int MSS_P = 1460,
    parameter int PTR_W = TX_PAYLOAD_PTR_W + 1
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                sched_tx_cmd_val,
    input  logic [FLOWID_W-1:0] sched_tx_cmd_flowid,
    output logic                tx_sched_cmd_rdy,

    output logic                tx_state_rd_req_val,
    output logic [FLOWID_W-1:0] tx_state_rd_req_addr,
    input  logic                tx_state_rd_req_rdy,
    input  logic                tx_state_rd_resp_val,
    input  smol_tx_state_struct tx_state_rd_resp_data,
    output logic                tx_state_rd_resp_rdy,

    output logic                tx_head_ptr_rd_req_val,
    output logic [FLOWID_W-1:0] tx_head_ptr_rd_req_addr,
    input  logic                tx_head_ptr_rd_req_rdy,
    input  logic                tx_head_ptr_rd_resp_val,
    input  logic [PTR_W-1:0]    tx_head_ptr_rd_resp_data,
    output logic                tx_head_ptr_rd_resp_rdy,

    output logic                tx_tail_ptr_rd_req_val,
    output logic [FLOWID_W-1:0] tx_tail_ptr_rd_req_addr,
    input  logic                tx_tail_ptr_rd_req_rdy,
    input  logic                tx_tail_ptr_rd_resp_val,
    input  logic [PTR_W-1:0]    tx_tail_ptr_rd_resp_data,
    output logic                tx_tail_ptr_rd_resp_rdy,

    output logic                tx_head_ptr_wr_req_val,
    output logic [FLOWID_W-1:0] tx_head_ptr_wr_req_addr,
    output logic [PTR_W-1:0]    tx_head_ptr_wr_req_data,
    input  logic                tx_head_ptr_wr_req_rdy,

    output logic                tx_state_wr_req_val,
    output logic [FLOWID_W-1:0] tx_state_wr_req_addr,
    output smol_tx_state_struct tx_state_wr_req_data,
    input  logic                tx_state_wr_req_rdy,

    output logic                tx_send_pkt_enq_val,
    output logic [FLOWID_W-1:0] tx_send_pkt_enq_flowid,
    output tcp_pkt_hdr          tx_send_pkt_enq_pkt,
    output logic [PTR_W-1:0]    tx_send_pkt_enq_payload_ptr,
    output logic [15:0]         tx_send_pkt_enq_payload_len,
    input  logic                send_pkt_tx_enq_rdy
);

    localparam logic [31:0] c_mss_ext = 32'(MSS_P);
    localparam logic [15:0] c_mss_len = 16'(MSS_P);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_CALC    = 3'd3,
        ST_WR_BACK = 3'd4,
        ST_ENQ     = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [FLOWID_W-1:0] r_flowid;
    logic [2:0]          r_rd_pend;    // {tail, head, state} requests still outstanding
    logic [2:0]          r_resp_got;   // {tail, head, state} responses captured
    logic [1:0]          r_wr_pend;    // {state, head} writes still outstanding
    smol_tx_state_struct r_tx_state;
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [15:0]         r_len;
    logic [PTR_W-1:0]    r_new_head;
    smol_tx_state_struct r_new_state;

    logic                w_run;
    logic [2:0]          w_rd_fire;
    logic [2:0]          w_resp_fire;
    logic [1:0]          w_wr_fire;
    logic [PTR_W-1:0]    w_unsent;
    logic [31:0]         w_unsent_ext;
    logic [15:0]         w_len_mss;
    logic [15:0]         w_len;
    logic [PTR_W-1:0]    w_new_head;
    smol_tx_state_struct w_new_state;

    // Handshake outputs are forced low throughout reset.
    assign w_run = ~rst;

    assign tx_sched_cmd_rdy        = w_run & (r_state == ST_IDLE);

    assign tx_state_rd_req_val     = w_run & (r_state == ST_RD_REQ) & r_rd_pend[0];
    assign tx_head_ptr_rd_req_val  = w_run & (r_state == ST_RD_REQ) & r_rd_pend[1];
    assign tx_tail_ptr_rd_req_val  = w_run & (r_state == ST_RD_REQ) & r_rd_pend[2];
    assign tx_state_rd_req_addr    = r_flowid;
    assign tx_head_ptr_rd_req_addr = r_flowid;
    assign tx_tail_ptr_rd_req_addr = r_flowid;

    assign tx_state_rd_resp_rdy    = w_run & (r_state == ST_RD_WAIT) & ~r_resp_got[0];
    assign tx_head_ptr_rd_resp_rdy = w_run & (r_state == ST_RD_WAIT) & ~r_resp_got[1];
    assign tx_tail_ptr_rd_resp_rdy = w_run & (r_state == ST_RD_WAIT) & ~r_resp_got[2];

    assign tx_head_ptr_wr_req_val  = w_run & (r_state == ST_WR_BACK) & r_wr_pend[0];
    assign tx_state_wr_req_val     = w_run & (r_state == ST_WR_BACK) & r_wr_pend[1];
    assign tx_head_ptr_wr_req_addr = r_flowid;
    assign tx_state_wr_req_addr    = r_flowid;
    assign tx_head_ptr_wr_req_data = r_new_head;
    assign tx_state_wr_req_data    = r_new_state;

    // The segment carries the pre-increment sequence number and old head.
    assign tx_send_pkt_enq_val          = w_run & (r_state == ST_ENQ);
    assign tx_send_pkt_enq_flowid       = r_flowid;
    assign tx_send_pkt_enq_pkt.seq_num  = r_tx_state.seq_num;
    assign tx_send_pkt_enq_pkt.ack_num  = r_tx_state.ack_num;
    assign tx_send_pkt_enq_pkt.flags    = c_flag_ack | c_flag_psh;
    assign tx_send_pkt_enq_payload_ptr  = r_head;
    assign tx_send_pkt_enq_payload_len  = r_len;

    assign w_rd_fire   = {tx_tail_ptr_rd_req_val & tx_tail_ptr_rd_req_rdy,
                          tx_head_ptr_rd_req_val & tx_head_ptr_rd_req_rdy,
                          tx_state_rd_req_val    & tx_state_rd_req_rdy};
    assign w_resp_fire = {tx_tail_ptr_rd_resp_val & tx_tail_ptr_rd_resp_rdy,
                          tx_head_ptr_rd_resp_val & tx_head_ptr_rd_resp_rdy,
                          tx_state_rd_resp_val    & tx_state_rd_resp_rdy};
    assign w_wr_fire   = {tx_state_wr_req_val    & tx_state_wr_req_rdy,
                          tx_head_ptr_wr_req_val & tx_head_ptr_wr_req_rdy};

    // Pointer difference wraps naturally through the MSB wrap bit.
    assign w_unsent     = r_tail - r_head;
    assign w_unsent_ext = 32'(w_unsent);
    assign w_len_mss    = (w_unsent_ext < c_mss_ext) ? w_unsent_ext[15:0] : c_mss_len;

`ifdef TCP_TX_WND_CLAMP_EN
    assign w_len = (w_len_mss < r_tx_state.peer_wnd) ? w_len_mss : r_tx_state.peer_wnd;
`else
    assign w_len = w_len_mss;
`endif

    assign w_new_head = r_head + PTR_W'(w_len);

    always_comb begin
        w_new_state         = r_tx_state;
        w_new_state.seq_num = r_tx_state.seq_num + 32'(w_len);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (sched_tx_cmd_val) begin
                    w_state_nxt = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (&(~r_rd_pend | w_rd_fire)) begin
                    w_state_nxt = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (&(r_resp_got | w_resp_fire)) begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                w_state_nxt = (w_len == 16'd0) ? ST_IDLE : ST_WR_BACK;
            end
            ST_WR_BACK: begin
                if (&(~r_wr_pend | w_wr_fire)) begin
                    w_state_nxt = ST_ENQ;
                end
            end
            ST_ENQ: begin
                if (send_pkt_tx_enq_rdy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_flowid    <= '0;
            r_rd_pend   <= '0;
            r_resp_got  <= '0;
            r_wr_pend   <= '0;
            r_tx_state  <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_len       <= '0;
            r_new_head  <= '0;
            r_new_state <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (sched_tx_cmd_val) begin
                        r_flowid   <= sched_tx_cmd_flowid;
                        r_rd_pend  <= 3'b111;
                        r_resp_got <= 3'b000;
                    end
                end
                ST_RD_REQ: begin
                    r_rd_pend <= r_rd_pend & ~w_rd_fire;
                end
                ST_RD_WAIT: begin
                    if (w_resp_fire[0]) begin
                        r_tx_state <= tx_state_rd_resp_data;
                    end
                    if (w_resp_fire[1]) begin
                        r_head <= tx_head_ptr_rd_resp_data;
                    end
                    if (w_resp_fire[2]) begin
                        r_tail <= tx_tail_ptr_rd_resp_data;
                    end
                    r_resp_got <= r_resp_got | w_resp_fire;
                end
                ST_CALC: begin
                    r_len       <= w_len;
                    r_new_head  <= w_new_head;
                    r_new_state <= w_new_state;
                    r_wr_pend   <= 2'b11;
                end
                ST_WR_BACK: begin
                    r_wr_pend <= r_wr_pend & ~w_wr_fire;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tcp_tx_pkt_gen.sv
// ============================================================================
// Module   : tb_tcp_tx_pkt_gen
// Brief    : Directed self-checking bench for tcp_tx_pkt_gen with a cycle-level
//            responder model for the state/pointer memories and send queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tcp_tx_pkt_gen;
    import tcp_tx_pkt_gen_pkg::*;

    localparam int MSS = 1460;
    localparam int PW  = TX_PAYLOAD_PTR_W + 1;

`ifdef TCP_TX_WND_CLAMP_EN
    localparam logic [15:0] EXP_G_LEN = 16'd100;
`else
    localparam logic [15:0] EXP_G_LEN = 16'd500;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                sched_tx_cmd_val;
    logic [FLOWID_W-1:0] sched_tx_cmd_flowid;
    logic                tx_sched_cmd_rdy;
    logic                tx_state_rd_req_val;
    logic [FLOWID_W-1:0] tx_state_rd_req_addr;
    logic                tx_state_rd_req_rdy;
    logic                tx_state_rd_resp_val;
    smol_tx_state_struct tx_state_rd_resp_data;
    logic                tx_state_rd_resp_rdy;
    logic                tx_head_ptr_rd_req_val;
    logic [FLOWID_W-1:0] tx_head_ptr_rd_req_addr;
    logic                tx_head_ptr_rd_req_rdy;
    logic                tx_head_ptr_rd_resp_val;
    logic [PW-1:0]       tx_head_ptr_rd_resp_data;
    logic                tx_head_ptr_rd_resp_rdy;
    logic                tx_tail_ptr_rd_req_val;
    logic [FLOWID_W-1:0] tx_tail_ptr_rd_req_addr;
    logic                tx_tail_ptr_rd_req_rdy;
    logic                tx_tail_ptr_rd_resp_val;
    logic [PW-1:0]       tx_tail_ptr_rd_resp_data;
    logic                tx_tail_ptr_rd_resp_rdy;
    logic                tx_head_ptr_wr_req_val;
    logic [FLOWID_W-1:0] tx_head_ptr_wr_req_addr;
    logic [PW-1:0]       tx_head_ptr_wr_req_data;
    logic                tx_head_ptr_wr_req_rdy;
    logic                tx_state_wr_req_val;
    logic [FLOWID_W-1:0] tx_state_wr_req_addr;
    smol_tx_state_struct tx_state_wr_req_data;
    logic                tx_state_wr_req_rdy;
    logic                tx_send_pkt_enq_val;
    logic [FLOWID_W-1:0] tx_send_pkt_enq_flowid;
    tcp_pkt_hdr          tx_send_pkt_enq_pkt;
    logic [PW-1:0]       tx_send_pkt_enq_payload_ptr;
    logic [15:0]         tx_send_pkt_enq_payload_len;
    logic                send_pkt_tx_enq_rdy;

    tcp_tx_pkt_gen #(.MSS_P(MSS), .PTR_W(PW)) u_dut (
        .clk(clk), .rst(rst),
        .sched_tx_cmd_val(sched_tx_cmd_val), .sched_tx_cmd_flowid(sched_tx_cmd_flowid),
        .tx_sched_cmd_rdy(tx_sched_cmd_rdy),
        .tx_state_rd_req_val(tx_state_rd_req_val), .tx_state_rd_req_addr(tx_state_rd_req_addr),
        .tx_state_rd_req_rdy(tx_state_rd_req_rdy),
        .tx_state_rd_resp_val(tx_state_rd_resp_val), .tx_state_rd_resp_data(tx_state_rd_resp_data),
        .tx_state_rd_resp_rdy(tx_state_rd_resp_rdy),
        .tx_head_ptr_rd_req_val(tx_head_ptr_rd_req_val), .tx_head_ptr_rd_req_addr(tx_head_ptr_rd_req_addr),
        .tx_head_ptr_rd_req_rdy(tx_head_ptr_rd_req_rdy),
        .tx_head_ptr_rd_resp_val(tx_head_ptr_rd_resp_val), .tx_head_ptr_rd_resp_data(tx_head_ptr_rd_resp_data),
        .tx_head_ptr_rd_resp_rdy(tx_head_ptr_rd_resp_rdy),
        .tx_tail_ptr_rd_req_val(tx_tail_ptr_rd_req_val), .tx_tail_ptr_rd_req_addr(tx_tail_ptr_rd_req_addr),
        .tx_tail_ptr_rd_req_rdy(tx_tail_ptr_rd_req_rdy),
        .tx_tail_ptr_rd_resp_val(tx_tail_ptr_rd_resp_val), .tx_tail_ptr_rd_resp_data(tx_tail_ptr_rd_resp_data),
        .tx_tail_ptr_rd_resp_rdy(tx_tail_ptr_rd_resp_rdy),
        .tx_head_ptr_wr_req_val(tx_head_ptr_wr_req_val), .tx_head_ptr_wr_req_addr(tx_head_ptr_wr_req_addr),
        .tx_head_ptr_wr_req_data(tx_head_ptr_wr_req_data), .tx_head_ptr_wr_req_rdy(tx_head_ptr_wr_req_rdy),
        .tx_state_wr_req_val(tx_state_wr_req_val), .tx_state_wr_req_addr(tx_state_wr_req_addr),
        .tx_state_wr_req_data(tx_state_wr_req_data), .tx_state_wr_req_rdy(tx_state_wr_req_rdy),
        .tx_send_pkt_enq_val(tx_send_pkt_enq_val), .tx_send_pkt_enq_flowid(tx_send_pkt_enq_flowid),
        .tx_send_pkt_enq_pkt(tx_send_pkt_enq_pkt), .tx_send_pkt_enq_payload_ptr(tx_send_pkt_enq_payload_ptr),
        .tx_send_pkt_enq_payload_len(tx_send_pkt_enq_payload_len), .send_pkt_tx_enq_rdy(send_pkt_tx_enq_rdy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Responder model state
    int                  cyc = 0;
    logic                cmd_pending = 1'b0;
    logic                keep_pending = 1'b0;
    logic [FLOWID_W-1:0] m_flow = '0;
    logic [PW-1:0]       m_head = '0;
    logic [PW-1:0]       m_tail = '0;
    smol_tx_state_struct m_state = '0;
    int dly_st = 0, dly_hd = 0, dly_tl = 0;
    int cnt_st = -1, cnt_hd = -1, cnt_tl = -1;
    int stall_left = 0;

    // Observations
    int n_acc, n_hwr, n_swr, n_enq, n_resp_fire;
    int acc_cyc, rdy_cyc, enq_cyc, enq_fire_cyc;
    logic accepted, rdy_back, enq_seen, enq_stable;
    logic [FLOWID_W-1:0] cap_rd_addr, cap_hwr_addr, cap_swr_addr, cap_enq_flow;
    logic [PW-1:0]       cap_hwr_data, cap_enq_ptr;
    smol_tx_state_struct cap_swr_data;
    tcp_pkt_hdr          cap_enq_pkt;
    logic [15:0]         cap_enq_len;
    logic [127:0]        snap_enq;

    task automatic clear_stats();
        n_acc = 0; n_hwr = 0; n_swr = 0; n_enq = 0; n_resp_fire = 0;
        acc_cyc = 0; rdy_cyc = 0; enq_cyc = 0; enq_fire_cyc = 0;
        accepted = 1'b0; rdy_back = 1'b0; enq_seen = 1'b0; enq_stable = 1'b1;
        cap_rd_addr = '0; cap_hwr_addr = '0; cap_swr_addr = '0; cap_enq_flow = '0;
        cap_hwr_data = '0; cap_enq_ptr = '0; cap_swr_data = '0; cap_enq_pkt = '0;
        cap_enq_len = '0; snap_enq = '0;
        cnt_st = -1; cnt_hd = -1; cnt_tl = -1;
    endtask

    // One clock: drive inputs at negedge, then observe which handshakes fire at the next posedge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        sched_tx_cmd_val      = cmd_pending;
        sched_tx_cmd_flowid   = m_flow;
        tx_state_rd_resp_val    = (cnt_st == 0); if (cnt_st > 0) cnt_st--;
        tx_head_ptr_rd_resp_val = (cnt_hd == 0); if (cnt_hd > 0) cnt_hd--;
        tx_tail_ptr_rd_resp_val = (cnt_tl == 0); if (cnt_tl > 0) cnt_tl--;
        tx_state_rd_resp_data    = m_state;
        tx_head_ptr_rd_resp_data = m_head;
        tx_tail_ptr_rd_resp_data = m_tail;
        send_pkt_tx_enq_rdy      = (stall_left == 0);
        #1;
        if (tx_sched_cmd_rdy) begin
            if (accepted && !rdy_back) begin rdy_back = 1'b1; rdy_cyc = cyc; end
            if (sched_tx_cmd_val) begin
                n_acc++;
                if (!accepted) begin accepted = 1'b1; acc_cyc = cyc; end
                cmd_pending = keep_pending;
            end
        end
        if (tx_state_rd_req_val && tx_state_rd_req_rdy) begin cnt_st = dly_st; cap_rd_addr = tx_state_rd_req_addr; end
        if (tx_head_ptr_rd_req_val && tx_head_ptr_rd_req_rdy) cnt_hd = dly_hd;
        if (tx_tail_ptr_rd_req_val && tx_tail_ptr_rd_req_rdy) cnt_tl = dly_tl;
        if (tx_state_rd_resp_val && tx_state_rd_resp_rdy) begin cnt_st = -1; n_resp_fire++; end
        if (tx_head_ptr_rd_resp_val && tx_head_ptr_rd_resp_rdy) begin cnt_hd = -1; n_resp_fire++; end
        if (tx_tail_ptr_rd_resp_val && tx_tail_ptr_rd_resp_rdy) begin cnt_tl = -1; n_resp_fire++; end
        if (tx_head_ptr_wr_req_val && tx_head_ptr_wr_req_rdy) begin
            n_hwr++; cap_hwr_addr = tx_head_ptr_wr_req_addr; cap_hwr_data = tx_head_ptr_wr_req_data;
        end
        if (tx_state_wr_req_val && tx_state_wr_req_rdy) begin
            n_swr++; cap_swr_addr = tx_state_wr_req_addr; cap_swr_data = tx_state_wr_req_data;
        end
        if (tx_send_pkt_enq_val) begin
            if (!enq_seen) begin
                enq_seen = 1'b1; enq_cyc = cyc;
                snap_enq = {tx_send_pkt_enq_flowid, tx_send_pkt_enq_pkt,
                            tx_send_pkt_enq_payload_ptr, tx_send_pkt_enq_payload_len};
            end else if (snap_enq != {tx_send_pkt_enq_flowid, tx_send_pkt_enq_pkt,
                                      tx_send_pkt_enq_payload_ptr, tx_send_pkt_enq_payload_len}) begin
                enq_stable = 1'b0;
            end
            if (send_pkt_tx_enq_rdy) begin
                n_enq++; enq_fire_cyc = cyc;
                cap_enq_flow = tx_send_pkt_enq_flowid; cap_enq_pkt = tx_send_pkt_enq_pkt;
                cap_enq_ptr = tx_send_pkt_enq_payload_ptr; cap_enq_len = tx_send_pkt_enq_payload_len;
            end else begin
                stall_left--;
            end
        end
    endtask

    task automatic run_cmd(input logic [FLOWID_W-1:0] flow, input logic [PW-1:0] head, input logic [PW-1:0] tail,
                           input logic [31:0] seq, input logic [31:0] ack, input logic [15:0] wnd,
                           input int d_st, input int d_hd, input int d_tl, input int stall);
        clear_stats();
        m_flow = flow; m_head = head; m_tail = tail;
        m_state = {seq, ack, wnd};
        dly_st = d_st; dly_hd = d_hd; dly_tl = d_tl; stall_left = stall;
        cmd_pending = 1'b1;
        for (int i = 0; i < 200 && !rdy_back; i++) tick();
        check_val("cmd_done_in_budget", rdy_back, 1'b1);
    endtask

    function automatic logic [11:0] out_vec();
        return {tx_sched_cmd_rdy, tx_state_rd_req_val, tx_head_ptr_rd_req_val, tx_tail_ptr_rd_req_val,
                tx_state_rd_resp_rdy, tx_head_ptr_rd_resp_rdy, tx_tail_ptr_rd_resp_rdy,
                tx_head_ptr_wr_req_val, tx_state_wr_req_val, tx_send_pkt_enq_val, 2'b00};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tx_state_rd_req_rdy = 1'b1; tx_head_ptr_rd_req_rdy = 1'b1; tx_tail_ptr_rd_req_rdy = 1'b1;
        tx_head_ptr_wr_req_rdy = 1'b1; tx_state_wr_req_rdy = 1'b1;
        clear_stats();

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check_val("rst_outputs_low", out_vec(), 12'h000);
        rst = 1'b0;
        tick();
        check_val("rdy_after_rst", tx_sched_cmd_rdy, 1'b1);

        // Basic segment: 256 bytes
        run_cmd(8'd3, 13'h010, 13'h110, 32'd1000, 32'hABCD0123, 16'hFFFF, 0, 0, 0, 0);
        check_val("a_rd_addr", cap_rd_addr, 8'd3);
        check_val("a_n_enq", n_enq, 1);
        check_val("a_enq_flow", cap_enq_flow, 8'd3);
        check_val("a_enq_pkt", cap_enq_pkt, {32'd1000, 32'hABCD0123, 8'h18});
        check_val("a_enq_ptr", cap_enq_ptr, 13'h010);
        check_val("a_enq_len", cap_enq_len, 16'd256);
        check_val("a_n_hwr", n_hwr, 1);
        check_val("a_hwr_addr", cap_hwr_addr, 8'd3);
        check_val("a_hwr_data", cap_hwr_data, 13'h110);
        check_val("a_n_swr", n_swr, 1);
        check_val("a_swr_addr", cap_swr_addr, 8'd3);
        check_val("a_swr_data", cap_swr_data, {32'd1256, 32'hABCD0123, 16'hFFFF});
        check_val("a_latency", enq_cyc - acc_cyc - 1, 4);
        check_val("a_rdy_after_enq", rdy_cyc - enq_fire_cyc, 1);

        // MSS clamp with sequence number wrapping past 2^32
        run_cmd(8'd7, 13'd0, 13'd4000, 32'hFFFFFC00, 32'h11112222, 16'hFFFF, 0, 0, 0, 0);
        check_val("b_enq_len", cap_enq_len, 16'd1460);
        check_val("b_enq_seq", cap_enq_pkt.seq_num, 32'hFFFFFC00);
        check_val("b_hwr_data", cap_hwr_data, 13'd1460);
        check_val("b_swr_data", cap_swr_data, {32'h000001B4, 32'h11112222, 16'hFFFF});

        // Empty buffer: nothing emitted, ready again the cycle after CALC
        run_cmd(8'd9, 13'h123, 13'h123, 32'd55, 32'd66, 16'hFFFF, 0, 0, 0, 0);
        check_val("c_n_hwr", n_hwr, 0);
        check_val("c_n_swr", n_swr, 0);
        check_val("c_n_enq", n_enq, 0);
        check_val("c_rdy_return", rdy_cyc - acc_cyc, 4);

        // Tail has its wrap bit set
        run_cmd(8'd1, 13'h0FF0, 13'h1010, 32'd0, 32'd0, 16'hFFFF, 0, 0, 0, 0);
        check_val("d_enq_len", cap_enq_len, 16'h0020);
        check_val("d_hwr_data", cap_hwr_data, 13'h1010);

        // Head pointer wraps past 2^PTR_W
        run_cmd(8'd2, 13'h1FF0, 13'h0010, 32'd7, 32'd8, 16'hFFFF, 0, 0, 0, 0);
        check_val("e_enq_len", cap_enq_len, 16'h0020);
        check_val("e_hwr_data", cap_hwr_data, 13'h0010);
        check_val("e_enq_ptr", cap_enq_ptr, 13'h1FF0);

        // Out-of-order responses, send queue stalled, scheduler always offering
        keep_pending = 1'b1;
        run_cmd(8'd4, 13'h100, 13'h300, 32'd5000, 32'd77, 16'hFFFF, 3, 0, 1, 10);
        check_val("f_n_enq", n_enq, 1);
        check_val("f_enq_stable", enq_stable, 1'b1);
        check_val("f_stall_cycles", enq_fire_cyc - enq_cyc, 10);
        check_val("f_enq_len", cap_enq_len, 16'd512);
        check_val("f_enq_seq", cap_enq_pkt.seq_num, 32'd5000);
        check_val("f_next_acc_cycle", rdy_cyc - enq_fire_cyc, 1);
        check_val("f_n_acc", n_acc, 2);
        keep_pending = 1'b0;
        cmd_pending  = 1'b0;
        repeat (10) tick();
        check_val("f_second_enq", n_enq, 2);

        // Reset while waiting for responses, then stale responses arrive
        clear_stats();
        m_flow = 8'd6; m_head = 13'h000; m_tail = 13'h050;
        m_state = {32'd900, 32'd901, 16'hFFFF};
        dly_st = 4; dly_hd = 4; dly_tl = 4; stall_left = 0;
        cmd_pending = 1'b1;
        for (int i = 0; i < 10 && !accepted; i++) tick();
        check_val("g_accepted", accepted, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_val("g_rst_outputs_low", out_vec(), 12'h000);
        rst = 1'b0;
        tick();
        check_val("g_rdy_after_rst", tx_sched_cmd_rdy, 1'b1);
        repeat (8) tick();
        check_val("g_stale_resp", n_resp_fire, 0);
        check_val("g_n_hwr", n_hwr, 0);
        check_val("g_n_swr", n_swr, 0);
        check_val("g_n_enq", n_enq, 0);
        cnt_st = -1; cnt_hd = -1; cnt_tl = -1;
        tick();

        // Next command after the abandoned one, peer window 100 with 500 unsent
        run_cmd(8'd5, 13'h200, 13'h3F4, 32'd2000, 32'd3000, 16'd100, 0, 0, 0, 0);
        check_val("h_n_enq", n_enq, 1);
        check_val("h_enq_len", cap_enq_len, EXP_G_LEN);
        check_val("h_hwr_data", cap_hwr_data, 13'h200 + 13'(EXP_G_LEN));
        check_val("h_swr_seq", cap_swr_data.seq_num, 32'd2000 + 32'(EXP_G_LEN));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tcp_tx_pkt_gen.md
TCP_TX_PKT_GEN -- requirements
Module: tcp_tx_pkt_gen

Interface
REQ-001 Parameter MSS_P, default 1460, is the maximum payload bytes per generated segment.
REQ-002 Parameter PTR_W, default TX_PAYLOAD_PTR_W+1, is the width of the TX buffer pointers, including the wrap bit.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Scheduler port (sched_tx_cmd_val in, sched_tx_cmd_flowid in FLOWID_W, tx_sched_cmd_rdy out): one transmit opportunity per accepted command.
REQ-006 TX state read request (tx_state_rd_req_val out, tx_state_rd_req_addr out FLOWID_W, tx_state_rd_req_rdy in).
REQ-007 TX state read response (tx_state_rd_resp_val in, tx_state_rd_resp_data in smol_tx_state_struct, tx_state_rd_resp_rdy out).
REQ-008 TX pointer read requests, head and tail (tx_head_ptr_rd_req_val/addr/rdy, tx_tail_ptr_rd_req_val/addr/rdy), each with addr FLOWID_W.
REQ-009 TX pointer read responses, head and tail (tx_head_ptr_rd_resp_val/data/rdy, tx_tail_ptr_rd_resp_val/data/rdy), each with data PTR_W.
REQ-010 Writeback ports: tx_head_ptr_wr_req_val/addr/data(PTR_W)/rdy and tx_state_wr_req_val/addr/data(smol_tx_state_struct)/rdy.
REQ-011 Send-queue port (tx_send_pkt_enq_val out, tx_send_pkt_enq_flowid out, tx_send_pkt_enq_pkt out tcp_pkt_hdr, tx_send_pkt_enq_payload_ptr out PTR_W, tx_send_pkt_enq_payload_len out 16, send_pkt_tx_enq_rdy in).

Function
REQ-012 FSM states: IDLE, RD_REQ, RD_WAIT, CALC, WR_BACK, ENQ; exactly one command is in flight at a time.
REQ-013 IDLE asserts tx_sched_cmd_rdy; on val&rdy the block latches the flowid and enters RD_REQ.
REQ-014 RD_REQ drives all three read requests with addr=flowid; each request drops independently once accepted; the FSM enters RD_WAIT when all three are accepted.
REQ-015 RD_WAIT holds each resp_rdy high until that response arrives, latches the data, and enters CALC once all three responses are held, in any order or in the same cycle.
REQ-016 CALC takes one cycle: unsent = (tail - head) mod 2^PTR_W; len = min(unsent, MSS_P).
REQ-017 If len==0 the FSM returns to IDLE with no writes and no enqueue, so no empty segment is ever emitted.
REQ-018 Otherwise the FSM enters WR_BACK: head write data = (head + len) mod 2^PTR_W, with wrap carried into the MSB.
REQ-019 In WR_BACK the state write data is the read state with the sequence number advanced by len, mod 2^32; all other fields are unchanged.
REQ-020 WR_BACK asserts both write requests; each drops independently on acceptance; the FSM enters ENQ once both are accepted.
REQ-021 In ENQ, header fields are: seq = pre-increment sequence number; ack = state ack number; flags ACK|PSH.
REQ-022 In ENQ, payload_ptr = old head and payload_len = len; all ENQ outputs are held stable until send_pkt_tx_enq_rdy, then the FSM returns to IDLE.
REQ-023 Every val output, once asserted, is held high with stable data until its handshake completes.
REQ-024 Minimum latency from command accept to enqueue val is 4 cycles, with all rdy inputs tied high.
REQ-025 A new command is accepted no earlier than the cycle after the enqueue handshake.

Reset
REQ-026 While rst is high: FSM=IDLE; every val and rdy output is 0; latched data is cleared to 0.
REQ-027 Reset asserted mid-operation abandons the command: no further write or enqueue is issued for it, and any write already accepted stands.
REQ-028 tx_sched_cmd_rdy returns to 1 in the first cycle after rst deasserts.

Configuration
REQ-029 Macro TCP_TX_WND_CLAMP_EN: when defined, len = min(unsent, MSS_P, peer window field of the state struct), and window 0 is handled like len 0.
REQ-030 When TCP_TX_WND_CLAMP_EN is undefined, the peer window is ignored and len = min(unsent, MSS_P).

Verification
REQ-031 flow 3, head=0x010, tail=0x110, seq=1000 -> one enqueue with seq 1000, len 256, ptr 0x010; head write 0x110; state seq 1256.
REQ-032 head=0, tail=4000 -> len 1460; head write 1460; seq advances by 1460.
REQ-033 head==tail -> no writes and no enqueue; tx_sched_cmd_rdy is high again 1 cycle after CALC.
REQ-034 PTR_W=13, head=0x0FF0, tail=0x1010 (wrap bit set) -> len 0x20; head write 0x1010.
REQ-035 Stall send_pkt_tx_enq_rdy low for 10 cycles and deliver read responses out of order -> outputs stay stable; exactly one enqueue; next command not accepted early.
REQ-036 rst pulsed while in RD_WAIT, then a stale response arrives -> no write and no enqueue; the next command is processed normally; with TCP_TX_WND_CLAMP_EN and peer window 100, unsent 500 gives len 100.
